// File: rtl/serial_bit_feeder_pkg.sv
// Shared types and defaults for the serial bit feeder and its bit-period divider.
package serial_bit_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 1;

    // Counter width able to hold 0..n-1; at least one bit so n=1 still has a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_feeder_tick.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the first and last cycle of each period.
module bit_tick_gen
    import serial_bit_feeder_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick_first,
    output logic tick_last
);

    localparam int            CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_first = enable && (cnt_q == '0);
    assign tick_last  = enable && (cnt_q == LAST);

    // Held at zero while disabled so every new word starts on a fresh period.
    always_comb begin
        cnt_d = '0;
        if (enable && !tick_last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_bit_feeder.sv
// Serializes parallel words onto x_out through a one-entry holding register,
// reloading back-to-back so consecutive words form a gapless bit stream.
module serial_bit_feeder
    import serial_bit_feeder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DIV       = DEFAULT_DIV,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int            BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;

    logic tick_first, tick_last;
    logic shifting, handshake, last_bit, load;

    assign shifting  = (state_q == SHIFT);
    assign in_ready  = ~hold_full_q;
    assign handshake = in_valid & in_ready;
    assign last_bit  = tick_last && (bit_cnt_q == LAST_BIT);
    assign load      = hold_full_q && (!shifting || last_bit);

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .enable     (shifting),
        .tick_first (tick_first),
        .tick_last  (tick_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hold_full_q) state_d = SHIFT;
            SHIFT:   if (last_bit && !hold_full_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_out     = 1'b0;
        bit_valid = 1'b0;
        word_done = 1'b0;
        busy      = 1'b0;
        if (shifting) begin
            busy      = 1'b1;
            x_out     = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];
            bit_valid = tick_first;
            word_done = last_bit;
        end
    end

    // Handshake and reload are mutually exclusive: a handshake needs hold_full clear, a reload needs it set.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        if (handshake) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
        if (load) begin
            shift_d   = hold_q;
            bit_cnt_d = '0;
        end else if (last_bit) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (tick_last) begin
            shift_d   = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

endmodule

// File: doc/serial_bit_feeder.md
SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

Interface
REQ-001 Parameter WIDTH, default 8, word width in bits (legal range 2..32).
REQ-002 Parameter DIV, default 1, clock cycles per serial bit (legal range 1..256).
REQ-003 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  feeder can accept a word this cycle.
REQ-009 x_out  output  1  serial bit stream; drives the sequence detector's x input.
REQ-010 bit_valid  output  1  one-cycle strobe marking the first cycle of each bit period.
REQ-011 word_done  output  1  one-cycle pulse in the last cycle of a word's final bit period.
REQ-012 busy  output  1  high while state is SHIFT.

Function
REQ-013 Handshake SHALL occur in any cycle with in_valid=1 and in_ready=1; in_data is then captured into a one-entry holding register and hold_full sets.
REQ-014 in_ready SHALL equal NOT hold_full (registered flag; no combinational path from in_valid).
REQ-015 The FSM SHALL have two states, IDLE and SHIFT.
REQ-016 IDLE: x_out=0, bit_valid=0, busy=0; if hold_full=1, next state SHIFT, with shift register loaded from the holding register, bit counter=0, divider counter=0, and hold_full cleared on the same edge.
REQ-017 SHIFT: x_out SHALL present the current bit (MSB or LSB of the shift register per MSB_FIRST), constant for DIV cycles.
REQ-018 The divider counter SHALL count 0..DIV-1 and wrap; bit_valid=1 exactly when state=SHIFT and the divider counter is 0.
REQ-019 At divider count DIV-1 with bit count < WIDTH-1: shift by one position and increment the bit count.
REQ-020 At divider count DIV-1 with bit count = WIDTH-1: assert word_done; if hold_full=1, reload per REQ-016 and remain in SHIFT with no gap cycle; otherwise go to IDLE.
REQ-021 Latency: handshake in cycle N -> first bit_valid and first bit on x_out in cycle N+2 when the feeder was IDLE.
REQ-022 Back-to-back words with hold_full set before the final bit period ends SHALL produce a contiguous stream (bit_valid every DIV cycles, no idle cycle).
REQ-023 Reload and a new handshake SHALL never coincide on the holding register, because in_ready=0 while hold_full=1; after a reload in_ready returns to 1 on the next cycle.
REQ-024 DIV=1 SHALL give bit_valid=1 on every SHIFT cycle and one bit per clock.
REQ-025 in_data SHALL be ignored whenever in_ready=0.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, hold_full=0, shift register=0, bit and divider counters=0.
REQ-027 During and after reset: in_ready=1, x_out=0, bit_valid=0, word_done=0, busy=0.
REQ-028 Reset asserted mid-word SHALL discard both the in-flight word and the held word, with no word_done.

Structure
REQ-029 A shared package SHALL hold the state encoding constants (IDLE, SHIFT) and the default WIDTH and DIV constants.
REQ-030 The divider SHALL be a sub-module named bit_tick_gen (parameter DIV; inputs clk, rst, enable; outputs tick_first and tick_last); all other logic stays in serial_bit_feeder.

Verification
REQ-031 WIDTH=8, DIV=1, MSB_FIRST=1, send 8'hB4 at cycle N -> x_out 1,0,1,1,0,1,0,0 in cycles N+2..N+9; word_done in N+9; busy=0 from N+10.
REQ-032 DIV=1, send 8'hA5 then 8'h3C with the second handshake while the first word is shifting -> 16 consecutive bit_valid cycles, x_out 10100101 00111100, two word_done pulses 8 cycles apart.
REQ-033 DIV=4, send 8'h81 -> each bit held 4 cycles, bit_valid every 4th cycle, 32 SHIFT cycles total, word_done in the 32nd.
REQ-034 MSB_FIRST=0, DIV=1, send 8'h01 -> x_out 1,0,0,0,0,0,0,0.
REQ-035 Hold full with in_valid held high and 8'hFF presented -> in_ready=0 until reload, and 8'hFF is captured only on the cycle in_ready returns to 1.
REQ-036 rst asserted at the 4th bit of 8'hF0 with a second word held -> outputs reach reset values immediately, no word_done, and after release the first new handshake starts from bit 0.
